// File: rtl/key_debouncer.sv
// key_debouncer: per-key two-flop synchronizer plus stability-window debouncer.
// Converts asynchronous, bouncing, active-low pushbutton levels into clean
// registered active-low levels, and emits one-cycle press/release pulses that
// line up with the first cycle in which the new debounced level is visible.
module key_debouncer #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw_n,
    output logic [NUM_KEYS-1:0] key_db_n,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);

    // Counter value on which a new level has held for the full window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } state_t;

    // Synchronizer chain; only r_sync2 is observed by the debouncers.
    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;

    // Per-channel debounce state.
    state_t              r_state     [NUM_KEYS];
    state_t              w_state_nxt [NUM_KEYS];
    logic [CNT_W-1:0]    r_cnt       [NUM_KEYS];
    logic [CNT_W-1:0]    w_cnt_nxt   [NUM_KEYS];

    // Registered outputs and their next values.
    logic [NUM_KEYS-1:0] r_db_n;
    logic [NUM_KEYS-1:0] r_press;
    logic [NUM_KEYS-1:0] r_release;
    logic [NUM_KEYS-1:0] w_db_nxt;
    logic [NUM_KEYS-1:0] w_press_nxt;
    logic [NUM_KEYS-1:0] w_release_nxt;

    // Two-flop synchronizer; resets to the released level so that no
    // spurious change is seen right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_raw_n;
            r_sync2 <= r_sync1;
        end
    end

    // Per-channel state and counter registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (reset) begin
                r_state[i] <= ST_STABLE;
                r_cnt[i]   <= '0;
            end else begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // Next-state logic: a differing level must hold for DEBOUNCE_CYCLES
    // consecutive cycles in CHANGING; any bounce back restarts the window.
    // The counter is held at zero outside CHANGING and never wraps.
    always_comb begin
        w_db_nxt      = r_db_n;
        w_press_nxt   = '0;
        w_release_nxt = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = '0;
            case (r_state[i])
                ST_STABLE: begin
                    if (r_sync2[i] != r_db_n[i]) begin
                        w_state_nxt[i] = ST_CHANGING;
                    end
                end
                ST_CHANGING: begin
                    if (r_sync2[i] == r_db_n[i]) begin
                        // Bounced back before the window elapsed.
                        w_state_nxt[i] = ST_STABLE;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        // New level accepted; pulse direction follows it.
                        w_db_nxt[i]      = r_sync2[i];
                        w_press_nxt[i]   = ~r_sync2[i];
                        w_release_nxt[i] = r_sync2[i];
                        w_state_nxt[i]   = ST_STABLE;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_STABLE;
                end
            endcase
        end
    end

    // Output registers; pulses self-clear because their next value
    // defaults to zero every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db_n    <= '1;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_db_n    <= w_db_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign key_db_n      = r_db_n;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed scenarios plus randomized traffic for
// key_debouncer, checked against a run-length reference model.
module tb_key_debouncer;

    localparam int NK = 4;
    localparam int DB = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] key_raw_n = '1;
    logic [NK-1:0] key_db_n;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the debouncer sees the pin two edges late; a key's
    // output flips on the (DB+1)-th consecutive edge at which the delayed
    // pin level disagrees with the current output.
    logic [NK-1:0] m_d0, m_d1, m_db, m_pr, m_rl;
    int            streak [NK];

    key_debouncer #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_raw_n(key_raw_n),
        .key_db_n(key_db_n),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        if ((1 << CW) < DB) begin
            $display("FAIL sizing: 2^CNT_W=%0d below DEBOUNCE_CYCLES=%0d", 1 << CW, DB);
            $fatal(1, "counter too narrow");
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic model_edge(input logic [NK-1:0] raw, input logic rst);
        if (rst) begin
            m_d0 = '1; m_d1 = '1; m_db = '1; m_pr = '0; m_rl = '0;
            for (int i = 0; i < NK; i++) streak[i] = 0;
        end else begin
            m_pr = '0; m_rl = '0;
            for (int i = 0; i < NK; i++) begin
                if (m_d1[i] != m_db[i]) begin
                    streak[i]++;
                    if (streak[i] == DB + 1) begin
                        m_db[i] = m_d1[i];
                        if (m_d1[i] == 1'b0) m_pr[i] = 1'b1;
                        else                 m_rl[i] = 1'b1;
                        streak[i] = 0;
                    end
                end else begin
                    streak[i] = 0;
                end
            end
            m_d1 = m_d0;
            m_d0 = raw;
        end
    endtask

    // Apply one cycle of stimulus, advance the model, settle after the edge.
    task automatic tick(input logic [NK-1:0] raw, input logic rst);
        key_raw_n = raw;
        reset     = rst;
        @(posedge clk);
        model_edge(raw, rst);
        #1;
    endtask

    task automatic test_reset();
        tick(4'hF, 1'b1);
        vectors++;
        if ({key_db_n, press_pulse, release_pulse} !== {4'hF, 4'h0, 4'h0}) begin
            miscompares++;
            $display("FAIL reset_values: got db=%h pr=%h rl=%h, want F/0/0", key_db_n, press_pulse, release_pulse);
        end
        tick(4'hF, 1'b1);
        tick(4'hF, 1'b1);
        for (int c = 0; c < 50; c++) begin
            tick(4'hF, 1'b0);
            vectors++;
            if ({key_db_n, press_pulse, release_pulse} !== {4'hF, 4'h0, 4'h0}) begin
                miscompares++;
                $display("FAIL idle c=%0d: got db=%h pr=%h rl=%h, want F/0/0", c, key_db_n, press_pulse, release_pulse);
            end
        end
    endtask

    task automatic test_clean_press();
        int n;
        tick(4'hE, 1'b0);
        n = 0;
        while (key_db_n === 4'hF && n < 40) begin
            tick(4'hE, 1'b0);
            n++;
            vectors++;
            if ({key_db_n, press_pulse, release_pulse} !== {m_db, m_pr, m_rl}) begin
                miscompares++;
                $display("FAIL press_model: got %h/%h/%h, want %h/%h/%h", key_db_n, press_pulse, release_pulse, m_db, m_pr, m_rl);
            end
        end
        vectors++;
        if (n !== 18 || key_db_n !== 4'hE) begin
            miscompares++;
            $display("FAIL press_latency: got %0d edges db=%h, want 18 edges db=E", n, key_db_n);
        end
        vectors++;
        if (press_pulse !== 4'h1 || release_pulse !== 4'h0) begin
            miscompares++;
            $display("FAIL press_pulse: got pr=%h rl=%h, want 1/0", press_pulse, release_pulse);
        end
        tick(4'hE, 1'b0);
        vectors++;
        if (press_pulse !== 4'h0 || key_db_n !== 4'hE) begin
            miscompares++;
            $display("FAIL press_width: got pr=%h db=%h, want 0/E", press_pulse, key_db_n);
        end
        tick(4'hF, 1'b0);
        n = 0;
        while (key_db_n === 4'hE && n < 40) begin
            tick(4'hF, 1'b0);
            n++;
            vectors++;
            if ({key_db_n, press_pulse, release_pulse} !== {m_db, m_pr, m_rl}) begin
                miscompares++;
                $display("FAIL release_model: got %h/%h/%h, want %h/%h/%h", key_db_n, press_pulse, release_pulse, m_db, m_pr, m_rl);
            end
        end
        vectors++;
        if (n !== 18 || key_db_n !== 4'hF || release_pulse !== 4'h1 || press_pulse !== 4'h0) begin
            miscompares++;
            $display("FAIL release: got %0d edges db=%h rl=%h pr=%h, want 18/F/1/0", n, key_db_n, release_pulse, press_pulse);
        end
        tick(4'hF, 1'b0);
        vectors++;
        if (release_pulse !== 4'h0) begin
            miscompares++;
            $display("FAIL release_width: got rl=%h, want 0", release_pulse);
        end
    endtask

    task automatic test_bounce();
        int n;
        logic [NK-1:0] raw;
        for (int c = 0; c < 60; c++) begin
            raw = 4'hF;
            raw[1] = ((c / 5) % 2 == 0) ? 1'b0 : 1'b1;
            tick(raw, 1'b0);
            vectors++;
            if ({key_db_n, press_pulse, release_pulse} !== {4'hF, 4'h0, 4'h0}) begin
                miscompares++;
                $display("FAIL bounce_hold c=%0d: got %h/%h/%h, want F/0/0", c, key_db_n, press_pulse, release_pulse);
            end
        end
        tick(4'hD, 1'b0);
        n = 0;
        while (key_db_n === 4'hF && n < 40) begin
            tick(4'hD, 1'b0);
            n++;
            vectors++;
            if ({key_db_n, press_pulse, release_pulse} !== {m_db, m_pr, m_rl}) begin
                miscompares++;
                $display("FAIL bounce_model: got %h/%h/%h, want %h/%h/%h", key_db_n, press_pulse, release_pulse, m_db, m_pr, m_rl);
            end
        end
        vectors++;
        if (n !== 18 || key_db_n !== 4'hD || press_pulse !== 4'h2) begin
            miscompares++;
            $display("FAIL bounce_settle: got %0d edges db=%h pr=%h, want 18/D/2", n, key_db_n, press_pulse);
        end
        for (int c = 0; c < 25; c++) tick(4'hF, 1'b0);
        // Glitch on key 3 seen by the debouncer while its counter sits at 15.
        tick(4'h7, 1'b0);
        for (int c = 0; c < 15; c++) tick(4'h7, 1'b0);
        tick(4'hF, 1'b0);
        n = 0;
        while (key_db_n === 4'hF && n < 60) begin
            tick(4'h7, 1'b0);
            n++;
            vectors++;
            if ({key_db_n, press_pulse, release_pulse} !== {m_db, m_pr, m_rl}) begin
                miscompares++;
                $display("FAIL glitch_model: got %h/%h/%h, want %h/%h/%h", key_db_n, press_pulse, release_pulse, m_db, m_pr, m_rl);
            end
        end
        vectors++;
        if (n !== 19 || key_db_n !== 4'h7 || press_pulse !== 4'h8) begin
            miscompares++;
            $display("FAIL glitch_restart: got %0d edges db=%h pr=%h, want 19/7/8", n, key_db_n, press_pulse);
        end
        for (int c = 0; c < 25; c++) tick(4'hF, 1'b0);
    endtask

    task automatic test_simultaneous();
        int n;
        int pc;
        int pcyc [4];
        logic [NK-1:0] pval [4];
        logic [NK-1:0] raw;
        logic [NK-1:0] expv;
        tick(4'h0, 1'b0);
        n = 0;
        while (key_db_n === 4'hF && n < 40) begin
            tick(4'h0, 1'b0);
            n++;
        end
        vectors++;
        if (n !== 18 || key_db_n !== 4'h0 || press_pulse !== 4'hF) begin
            miscompares++;
            $display("FAIL simul_press: got %0d edges db=%h pr=%h, want 18/0/F", n, key_db_n, press_pulse);
        end
        tick(4'h0, 1'b0);
        vectors++;
        if (press_pulse !== 4'h0) begin
            miscompares++;
            $display("FAIL simul_width: got pr=%h, want 0", press_pulse);
        end
        for (int c = 0; c < 25; c++) tick(4'hF, 1'b0);
        vectors++;
        if (key_db_n !== 4'hF) begin
            miscompares++;
            $display("FAIL simul_release: got db=%h, want F", key_db_n);
        end
        pc = 0;
        for (int c = 0; c < 45; c++) begin
            raw = 4'hF;
            for (int i = 0; i < NK; i++) if (c >= 3 * i) raw[i] = 1'b0;
            tick(raw, 1'b0);
            vectors++;
            if ({key_db_n, press_pulse, release_pulse} !== {m_db, m_pr, m_rl}) begin
                miscompares++;
                $display("FAIL stagger_model c=%0d: got %h/%h/%h, want %h/%h/%h", c, key_db_n, press_pulse, release_pulse, m_db, m_pr, m_rl);
            end
            if (press_pulse !== 4'h0) begin
                if (pc < 4) begin
                    pcyc[pc] = c;
                    pval[pc] = press_pulse;
                end
                pc++;
            end
        end
        vectors++;
        if (pc !== 4) begin
            miscompares++;
            $display("FAIL stagger_count: got %0d press pulses, want 4", pc);
        end else begin
            for (int i = 0; i < 4; i++) begin
                expv = 4'b0001 << i;
                vectors++;
                if (pval[i] !== expv || pcyc[i] !== 18 + 3 * i) begin
                    miscompares++;
                    $display("FAIL stagger_pulse %0d: got pr=%h at c=%0d, want %h at c=%0d", i, pval[i], pcyc[i], expv, 18 + 3 * i);
                end
            end
        end
        for (int c = 0; c < 25; c++) tick(4'hF, 1'b0);
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen_pulse;
        tick(4'hB, 1'b0);
        for (int c = 0; c < 12; c++) tick(4'hB, 1'b0);
        tick(4'hB, 1'b1);
        vectors++;
        if ({key_db_n, press_pulse, release_pulse} !== {4'hF, 4'h0, 4'h0}) begin
            miscompares++;
            $display("FAIL rstmid_reset: got %h/%h/%h, want F/0/0", key_db_n, press_pulse, release_pulse);
        end
        tick(4'hB, 1'b0);
        seen_pulse = (press_pulse !== 4'h0) || (release_pulse !== 4'h0);
        n = 0;
        while (key_db_n === 4'hF && n < 40) begin
            tick(4'hB, 1'b0);
            n++;
            if (key_db_n === 4'hF && ((press_pulse !== 4'h0) || (release_pulse !== 4'h0))) seen_pulse = 1'b1;
        end
        vectors++;
        if (seen_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_early_pulse: got a pulse before acceptance, want none");
        end
        vectors++;
        if (n !== 18 || key_db_n !== 4'hB || press_pulse !== 4'h4) begin
            miscompares++;
            $display("FAIL rstmid_accept: got %0d edges db=%h pr=%h, want 18/B/4", n, key_db_n, press_pulse);
        end
        for (int c = 0; c < 25; c++) tick(4'hF, 1'b0);
    endtask

    task automatic test_random();
        logic [NK-1:0] lvl;
        logic [NK-1:0] prev_db;
        logic [NK-1:0] last_press;
        logic          rst;
        int            hold [NK];
        lvl = 4'hF;
        last_press = '0;
        prev_db = key_db_n;
        for (int i = 0; i < NK; i++) hold[i] = $urandom_range(1, 30);
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NK; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    lvl[i] = ~lvl[i];
                    hold[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 8) : $urandom_range(17, 45);
                end
            end
            rst = ($urandom_range(0, 1999) == 0);
            tick(lvl, rst);
            vectors++;
            if ({key_db_n, press_pulse, release_pulse} !== {m_db, m_pr, m_rl}) begin
                miscompares++;
                $display("FAIL rand_model c=%0d: got %h/%h/%h, want %h/%h/%h", c, key_db_n, press_pulse, release_pulse, m_db, m_pr, m_rl);
            end
            vectors++;
            if ((press_pulse & release_pulse) !== 4'h0) begin
                miscompares++;
                $display("FAIL rand_both c=%0d: got pr=%h rl=%h, want disjoint", c, press_pulse, release_pulse);
            end
            if (rst) begin
                last_press = '0;
            end else begin
                vectors++;
                if (press_pulse !== (prev_db & ~key_db_n) || release_pulse !== (~prev_db & key_db_n)) begin
                    miscompares++;
                    $display("FAIL rand_edge c=%0d: got pr=%h rl=%h, want %h/%h", c, press_pulse, release_pulse, prev_db & ~key_db_n, ~prev_db & key_db_n);
                end
                for (int i = 0; i < NK; i++) begin
                    if (press_pulse[i] === 1'b1 || release_pulse[i] === 1'b1) begin
                        vectors++;
                        if (press_pulse[i] === last_press[i]) begin
                            miscompares++;
                            $display("FAIL rand_alternate c=%0d key=%0d: got pr=%b after last_press=%b, want alternation", c, i, press_pulse[i], last_press[i]);
                        end
                        last_press[i] = press_pulse[i];
                    end
                end
            end
            prev_db = key_db_n;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
